// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, error codes and default timing for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RST_CPU,
        RUN,
        HALTED,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int DEF_MEM_DEPTH      = 256;
    localparam int DEF_RESET_CYCLES   = 9;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    function automatic logic is_busy(input state_t s);
        return !(s == IDLE || s == HALTED || s == ERROR);
    endfunction

endpackage

// File: rtl/loader_run_timer.sv
// loader_run_timer: CPU-reset down-counter plus run/timeout up-counter for prog_loader.
// With LOADER_CYCLE_COUNT_EN the run counter is 32 bits, saturating, and exported.
module loader_run_timer #(
    parameter int RESET_CYCLES   = 9,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_rst_en,
    input  logic        i_run_en,
    output logic        o_rst_tc,
    output logic        o_run_tc
`ifdef LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0] o_run_cnt
`endif
);

`ifdef LOADER_CYCLE_COUNT_EN
    localparam int RUN_W = 32;
`else
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
`endif
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [RST_W-1:0] r_rst_cnt;
    logic [RUN_W-1:0] r_run_cnt;

    // Loading arms the reset window and starts a fresh run count in the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rst_cnt <= '0;
            r_run_cnt <= '0;
        end else if (i_load) begin
            r_rst_cnt <= RST_W'(RESET_CYCLES - 1);
            r_run_cnt <= '0;
        end else begin
            if (i_rst_en && r_rst_cnt != '0)
                r_rst_cnt <= r_rst_cnt - RST_W'(1);
            if (i_run_en && r_run_cnt != '1)
                r_run_cnt <= r_run_cnt + RUN_W'(1);
        end
    end

    assign o_rst_tc = r_rst_cnt == '0;
    assign o_run_tc = r_run_cnt == RUN_W'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CYCLE_COUNT_EN
    assign o_run_cnt = r_run_cnt;
`endif

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into CPU instruction memory, then resets, runs and supervises the CPU.
// Optional LOADER_CYCLE_COUNT_EN exports the 32-bit run_cycles counter.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
    input  logic        start,
    input  logic        reload,
    output logic        instr2memory_en,
    output logic        I_memory_en,
    output logic [15:0] instr2memory_addr,
    output logic [15:0] instr_in,
    output logic        cpu_clr_n,
    output logic        PC_en,
    input  logic        HLT,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [15:0] prog_len
`ifdef LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0] run_cycles
`endif
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wr_ptr;
    logic        w_acc;
    logic        w_ovf;
    logic        w_wr;
    logic        w_rel;
    logic        w_load;
    logic        w_rst_tc;
    logic        w_run_tc;

    assign w_acc  = s_valid && s_ready;
    assign w_ovf  = w_acc && (r_wr_ptr == 16'(MEM_DEPTH));
    assign w_wr   = w_acc && !w_ovf;
    assign w_rel  = reload && (r_state == HALTED || r_state == ERROR);
    assign w_load = (w_next == RST_CPU) && (r_state != RST_CPU);

    loader_run_timer #(
        .RESET_CYCLES  (RESET_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (CLK),
        .i_rst    (clr),
        .i_load   (w_load),
        .i_rst_en (r_state == RST_CPU),
        .i_run_en (r_state == RUN),
        .o_rst_tc (w_rst_tc),
        .o_run_tc (w_run_tc)
`ifdef LOADER_CYCLE_COUNT_EN
        ,
        .o_run_cnt(run_cycles)
`endif
    );

    // LOAD with s_ready already dropped is the final-word write cycle; SETTLE follows it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = w_ovf ? ERROR : LOAD;
                     else if (!s_valid && start) w_next = RST_CPU;
            LOAD:    if (!s_ready) w_next = SETTLE;
                     else if (w_ovf) w_next = ERROR;
            SETTLE:  w_next = RST_CPU;
            RST_CPU: if (w_rst_tc) w_next = RUN;
            RUN:     if (HLT) w_next = HALTED;
                     else if (w_run_tc) w_next = ERROR;
            HALTED:  if (reload) w_next = IDLE;
                     else if (start) w_next = RST_CPU;
            ERROR:   if (reload) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge clr) begin
        if (clr) begin
            r_state           <= IDLE;
            r_wr_ptr          <= '0;
            s_ready           <= 1'b0;
            instr2memory_en   <= 1'b1;
            I_memory_en       <= 1'b0;
            instr2memory_addr <= '0;
            instr_in          <= '0;
            cpu_clr_n         <= 1'b0;
            PC_en             <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= ERR_NONE;
        end else begin
            r_state         <= w_next;
            s_ready         <= (w_next == IDLE || w_next == LOAD) && !(w_acc && s_last);
            I_memory_en     <= w_wr;
            instr2memory_en <= !(w_next == RST_CPU || w_next == RUN);
            cpu_clr_n       <= w_next == RUN;
            PC_en           <= w_next == RST_CPU || w_next == RUN;
            busy            <= is_busy(w_next);
            done            <= w_next == HALTED;
            if (w_wr) begin
                instr2memory_addr <= r_wr_ptr;
                instr_in          <= s_data;
            end
            if (w_rel)
                r_wr_ptr <= '0;
            else if (w_wr)
                r_wr_ptr <= r_wr_ptr + 16'd1;
            if (w_rel)
                err <= ERR_NONE;
            else if (w_ovf)
                err <= ERR_OVF;
            else if (r_state == RUN && w_next == ERROR)
                err <= ERR_TMO;
        end
    end

    assign prog_len = r_wr_ptr;

endmodule
